// File: rtl/exc_arbiter_pkg.sv
// Shared types, cause codes and vector helpers for the commit-side exception arbiter.
package exc_arbiter_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 5;
    localparam int unsigned CE_W   = 4;

    localparam logic [CODE_W-1:0] CODE_INT  = 5'd0;
    localparam logic [CODE_W-1:0] CODE_MOD  = 5'd1;
    localparam logic [CODE_W-1:0] CODE_TLBL = 5'd2;
    localparam logic [CODE_W-1:0] CODE_TLBS = 5'd3;
    localparam logic [CODE_W-1:0] CODE_ADEL = 5'd4;
    localparam logic [CODE_W-1:0] CODE_ADES = 5'd5;
    localparam logic [CODE_W-1:0] CODE_IBE  = 5'd6;
    localparam logic [CODE_W-1:0] CODE_DBE  = 5'd7;
    localparam logic [CODE_W-1:0] CODE_SYS  = 5'd8;
    localparam logic [CODE_W-1:0] CODE_BP   = 5'd9;
    localparam logic [CODE_W-1:0] CODE_RI   = 5'd10;
    localparam logic [CODE_W-1:0] CODE_CPU  = 5'd11;
    localparam logic [CODE_W-1:0] CODE_OV   = 5'd12;
    localparam logic [CODE_W-1:0] CODE_TR   = 5'd13;

    localparam logic [XLEN-1:0] BASE_NORMAL    = 32'h8000_0000;
    localparam logic [XLEN-1:0] BASE_BEV       = 32'hbfc0_0200;
    localparam logic [XLEN-1:0] OFFSET_REFILL  = 32'h0000_0000;
    localparam logic [XLEN-1:0] OFFSET_GENERAL = 32'h0000_0180;
    localparam logic [XLEN-1:0] OFFSET_INT     = 32'h0000_0200;

    typedef struct packed {
        logic              valid;
        logic [CODE_W-1:0] code;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   badvaddr;
        logic              bd;
        logic [CE_W-1:0]   ce;
    } exception_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [XLEN-1:0]   pc;
        logic              bd;
        logic [XLEN-1:0]   badvaddr;
        logic [CE_W-1:0]   ce;
        logic              refill;
        logic              is_eret;
        logic              exl;
        logic [XLEN-1:0]   vector;
    } exc_sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } arb_state_e;

    function automatic logic [XLEN-1:0] exc_vector(input logic [CODE_W-1:0] code,
                                                   input logic refill, input logic exl,
                                                   input logic bev, input logic iv);
        logic [XLEN-1:0] base;
        logic [XLEN-1:0] offset;
        base = bev ? BASE_BEV : BASE_NORMAL;
        if (refill && !exl)
            offset = OFFSET_REFILL;
        else if (code == CODE_INT && iv)
            offset = OFFSET_INT;
        else
            offset = OFFSET_GENERAL;
        return base + offset;
    endfunction

    // Address-related causes that report the faulting address in BadVAddr.
    function automatic logic has_badvaddr(input logic [CODE_W-1:0] code);
        return (code == CODE_MOD) || (code == CODE_TLBL) || (code == CODE_TLBS) ||
               (code == CODE_ADEL) || (code == CODE_ADES);
    endfunction

endpackage

// File: rtl/exc_arbiter_if.sv
// Pipeline/CP0 bundle between the core (master) and the exception arbiter (slave).
interface exc_arbiter_if
    import exc_arbiter_pkg::*;
#(
    parameter int unsigned NSRC  = 3,
    parameter int unsigned INT_W = 6
);
    exception_t [NSRC-1:0] exc_i;
    logic [NSRC-1:0]       refill_i;
    logic                  slot_valid_i;
    logic [XLEN-1:0]       slot_pc_i;
    logic                  slot_bd_i;
    logic                  eret_i;
    logic [INT_W-1:0]      hw_int_i;
    logic [1:0]            sw_int_i;
    logic                  status_ie_i;
    logic                  status_exl_i;
    logic                  status_bev_i;
    logic                  cause_iv_i;
    logic [INT_W+1:0]      status_im_i;
    logic [XLEN-1:0]       epc_i;
    logic                  mem_busy_i;

    logic                  stall_o;
    logic [NSRC-1:0]       flush_o;
    logic                  redirect_valid_o;
    logic [XLEN-1:0]       redirect_pc_o;
    logic                  cp0_we_o;
    logic [CODE_W-1:0]     cp0_code_o;
    logic                  cp0_bd_o;
    logic [CE_W-1:0]       cp0_ce_o;
    logic                  cp0_epc_we_o;
    logic [XLEN-1:0]       cp0_epc_o;
    logic                  cp0_badvaddr_we_o;
    logic [XLEN-1:0]       cp0_badvaddr_o;
    logic                  exl_set_o;
    logic                  exl_clr_o;
    logic [INT_W+1:0]      int_pending_o;

    modport master (
        output exc_i, refill_i, slot_valid_i, slot_pc_i, slot_bd_i, eret_i,
               hw_int_i, sw_int_i, status_ie_i, status_exl_i, status_bev_i,
               cause_iv_i, status_im_i, epc_i, mem_busy_i,
        input  stall_o, flush_o, redirect_valid_o, redirect_pc_o, cp0_we_o,
               cp0_code_o, cp0_bd_o, cp0_ce_o, cp0_epc_we_o, cp0_epc_o,
               cp0_badvaddr_we_o, cp0_badvaddr_o, exl_set_o, exl_clr_o, int_pending_o
    );

    modport slave (
        input  exc_i, refill_i, slot_valid_i, slot_pc_i, slot_bd_i, eret_i,
               hw_int_i, sw_int_i, status_ie_i, status_exl_i, status_bev_i,
               cause_iv_i, status_im_i, epc_i, mem_busy_i,
        output stall_o, flush_o, redirect_valid_o, redirect_pc_o, cp0_we_o,
               cp0_code_o, cp0_bd_o, cp0_ce_o, cp0_epc_we_o, cp0_epc_o,
               cp0_badvaddr_we_o, cp0_badvaddr_o, exl_set_o, exl_clr_o, int_pending_o
    );
endinterface

// File: rtl/exc_arbiter_int_sync.sv
// Multi-bit flop-chain synchroniser for the asynchronous interrupt lines.
module int_sync #(
    parameter int unsigned W      = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES-1:0][W-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++)
                ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/exc_arbiter.sv
// Picks the oldest exception/interrupt/ERET, waits for memory to drain, then
// issues a single-cycle commit bundle (CP0 writes, flush, redirect).
module exc_arbiter
    import exc_arbiter_pkg::*;
#(
    parameter int unsigned NSRC        = 3,
    parameter int unsigned INT_W       = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic         clk,
    input logic         reset,
    exc_arbiter_if.slave bus
);
    arb_state_e       state;
    exc_sel_t         rec;
    exc_sel_t         sel_c;
    exc_sel_t         src_c;
    logic             sel_valid_c;
    logic             exc_found_c;
    logic             int_take_c;
    logic             commit_c;
    logic [INT_W-1:0] hw_sync;
    logic [INT_W+1:0] pending_c;

    int_sync #(.W(INT_W), .STAGES(SYNC_STAGES)) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.hw_int_i),
        .q     (hw_sync)
    );

    assign pending_c         = {hw_sync, bus.sw_int_i};
    assign bus.int_pending_o = pending_c;

    assign int_take_c = bus.status_ie_i & ~bus.status_exl_i &
                        (|(pending_c & bus.status_im_i)) & bus.slot_valid_i;

    // Priority select: interrupt, then oldest (highest-index) stage, then ERET.
    always_comb begin
        sel_c       = '0;
        sel_valid_c = 1'b0;
        exc_found_c = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.exc_i[k].valid) begin
                exc_found_c    = 1'b1;
                sel_c.code     = bus.exc_i[k].code;
                sel_c.pc       = bus.exc_i[k].pc;
                sel_c.bd       = bus.exc_i[k].bd;
                sel_c.badvaddr = bus.exc_i[k].badvaddr;
                sel_c.ce       = bus.exc_i[k].ce;
                sel_c.refill   = bus.refill_i[k];
            end
        end
        if (int_take_c) begin
            sel_c          = '0;
            sel_c.code     = CODE_INT;
            sel_c.pc       = bus.slot_pc_i;
            sel_c.bd       = bus.slot_bd_i;
            sel_valid_c    = 1'b1;
        end else if (exc_found_c) begin
            sel_valid_c    = 1'b1;
        end else if (bus.eret_i && !bus.exc_i[NSRC-1].valid) begin
            sel_c.is_eret  = 1'b1;
            sel_valid_c    = 1'b1;
        end
        sel_c.exl    = bus.status_exl_i;
        sel_c.vector = exc_vector(sel_c.code, sel_c.refill, bus.status_exl_i,
                                  bus.status_bev_i, bus.cause_iv_i);
    end

    assign src_c    = (state == IDLE) ? sel_c : rec;
    assign commit_c = ~bus.mem_busy_i &
                      (((state == IDLE) & sel_valid_c) | (state == DRAIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            rec                   <= '0;
            bus.stall_o           <= 1'b0;
            bus.flush_o           <= '0;
            bus.redirect_valid_o  <= 1'b0;
            bus.redirect_pc_o     <= '0;
            bus.cp0_we_o          <= 1'b0;
            bus.cp0_code_o        <= '0;
            bus.cp0_bd_o          <= 1'b0;
            bus.cp0_ce_o          <= '0;
            bus.cp0_epc_we_o      <= 1'b0;
            bus.cp0_epc_o         <= '0;
            bus.cp0_badvaddr_we_o <= 1'b0;
            bus.cp0_badvaddr_o    <= '0;
            bus.exl_set_o         <= 1'b0;
            bus.exl_clr_o         <= 1'b0;
        end else begin
            bus.flush_o           <= '0;
            bus.redirect_valid_o  <= 1'b0;
            bus.cp0_we_o          <= 1'b0;
            bus.cp0_epc_we_o      <= 1'b0;
            bus.cp0_badvaddr_we_o <= 1'b0;
            bus.exl_set_o         <= 1'b0;
            bus.exl_clr_o         <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_valid_c) begin
                        rec <= sel_c;
                        if (bus.mem_busy_i) begin
                            state       <= DRAIN;
                            bus.stall_o <= 1'b1;
                        end
                    end
                end
                DRAIN:   ;
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase

            // Commit bundle is registered on entry to COMMIT so it is live for that one cycle.
            if (commit_c) begin
                state                <= COMMIT;
                bus.stall_o          <= 1'b0;
                bus.flush_o          <= '1;
                bus.redirect_valid_o <= 1'b1;
                if (src_c.is_eret) begin
                    bus.redirect_pc_o <= bus.epc_i;
                    bus.exl_clr_o     <= 1'b1;
                end else begin
                    bus.redirect_pc_o     <= src_c.vector;
                    bus.cp0_we_o          <= 1'b1;
                    bus.cp0_code_o        <= src_c.code;
                    bus.cp0_bd_o          <= src_c.bd;
                    bus.cp0_ce_o          <= src_c.ce;
                    bus.exl_set_o         <= 1'b1;
                    bus.cp0_epc_we_o      <= ~src_c.exl;
                    bus.cp0_epc_o         <= src_c.bd ? (src_c.pc - 32'd4) : src_c.pc;
                    bus.cp0_badvaddr_we_o <= has_badvaddr(src_c.code);
                    bus.cp0_badvaddr_o    <= src_c.badvaddr;
                end
            end
        end
    end
endmodule

// File: tb/tb_exc_arbiter.sv
// Directed bench for exc_arbiter with hand-computed expected commit bundles.
module tb_exc_arbiter;
    import exc_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exc_arbiter_if #(.NSRC(3), .INT_W(6)) bus ();

    exc_arbiter #(.NSRC(3), .INT_W(6), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exception_t mk_exc(input logic [4:0] code, input logic [31:0] pc,
                                          input logic [31:0] bva, input logic bd);
        exception_t e;
        e          = '0;
        e.valid    = 1'b1;
        e.code     = code;
        e.pc       = pc;
        e.badvaddr = bva;
        e.bd       = bd;
        return e;
    endfunction

    task automatic idle_inputs();
        bus.exc_i        = '0;
        bus.refill_i     = '0;
        bus.slot_valid_i = 1'b1;
        bus.slot_pc_i    = '0;
        bus.slot_bd_i    = 1'b0;
        bus.eret_i       = 1'b0;
        bus.hw_int_i     = '0;
        bus.sw_int_i     = '0;
        bus.status_ie_i  = 1'b0;
        bus.status_exl_i = 1'b0;
        bus.status_bev_i = 1'b0;
        bus.cause_iv_i   = 1'b0;
        bus.status_im_i  = '0;
        bus.epc_i        = '0;
        bus.mem_busy_i   = 1'b0;
    endtask

    task automatic clear_events();
        bus.exc_i    = '0;
        bus.refill_i = '0;
        bus.eret_i   = 1'b0;
    endtask

    // Finish the COMMIT cycle and confirm the pulse is gone.
    task automatic retire(input string tag);
        clear_events();
        step();
        check({tag, "_pulse_end"}, 32'(bus.redirect_valid_o), 32'd0);
    endtask

    int stall_cnt;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        #12;
        check("rst_stall",    32'(bus.stall_o), 32'd0);
        check("rst_flush",    32'(bus.flush_o), 32'd0);
        check("rst_redirect", 32'(bus.redirect_valid_o), 32'd0);
        check("rst_pending",  32'(bus.int_pending_o), 32'd0);
        step();
        reset = 1'b0;
        step();

        // ADEL in stage 1 with BEV
        bus.status_bev_i = 1'b1;
        bus.exc_i[1] = mk_exc(CODE_ADEL, 32'h8000_1000, 32'h0000_1003, 1'b0);
        step();
        check("adel_rv",    32'(bus.redirect_valid_o), 32'd1);
        check("adel_pc",    bus.redirect_pc_o, 32'hbfc0_0380);
        check("adel_epc",   bus.cp0_epc_o, 32'h8000_1000);
        check("adel_epcwe", 32'(bus.cp0_epc_we_o), 32'd1);
        check("adel_bvawe", 32'(bus.cp0_badvaddr_we_o), 32'd1);
        check("adel_bva",   bus.cp0_badvaddr_o, 32'h0000_1003);
        check("adel_exl",   32'(bus.exl_set_o), 32'd1);
        check("adel_code",  32'(bus.cp0_code_o), 32'd4);
        check("adel_stall", 32'(bus.stall_o), 32'd0);
        retire("adel");
        bus.status_bev_i = 1'b0;

        // SYS in delay slot (stage 2) beats RI (stage 0)
        bus.exc_i[2] = mk_exc(CODE_SYS, 32'h8000_2004, 32'h0, 1'b1);
        bus.exc_i[0] = mk_exc(CODE_RI,  32'h8000_200c, 32'h0, 1'b0);
        step();
        check("sys_code",  32'(bus.cp0_code_o), 32'd8);
        check("sys_epc",   bus.cp0_epc_o, 32'h8000_2000);
        check("sys_bd",    32'(bus.cp0_bd_o), 32'd1);
        check("sys_flush", 32'(bus.flush_o), 32'h7);
        check("sys_pc",    bus.redirect_pc_o, 32'h8000_0180);
        check("sys_bvawe", 32'(bus.cp0_badvaddr_we_o), 32'd0);
        retire("sys");

        // TLBL refill, EXL clear then set
        bus.exc_i[2] = mk_exc(CODE_TLBL, 32'h8000_3000, 32'h0040_0000, 1'b0);
        bus.refill_i = 3'b100;
        step();
        check("refill_pc",    bus.redirect_pc_o, 32'h8000_0000);
        check("refill_epcwe", 32'(bus.cp0_epc_we_o), 32'd1);
        retire("refill");
        bus.status_exl_i = 1'b1;
        bus.exc_i[2] = mk_exc(CODE_TLBL, 32'h8000_3000, 32'h0040_0000, 1'b0);
        bus.refill_i = 3'b100;
        step();
        check("refill_exl_pc",    bus.redirect_pc_o, 32'h8000_0180);
        check("refill_exl_epcwe", 32'(bus.cp0_epc_we_o), 32'd0);
        retire("refill_exl");
        bus.status_exl_i = 1'b0;

        // Hardware interrupt through the synchroniser, IV vector
        bus.status_ie_i = 1'b1;
        bus.status_im_i = 8'b0000_0100;
        bus.cause_iv_i  = 1'b1;
        bus.slot_pc_i   = 32'h8000_4000;
        bus.hw_int_i    = 6'b000001;
        step();
        check("int_sync1",  32'(bus.int_pending_o), 32'h00);
        check("int_rv1",    32'(bus.redirect_valid_o), 32'd0);
        step();
        check("int_sync2",  32'(bus.int_pending_o), 32'h04);
        check("int_rv2",    32'(bus.redirect_valid_o), 32'd0);
        step();
        check("int_rv",     32'(bus.redirect_valid_o), 32'd1);
        check("int_pc",     bus.redirect_pc_o, 32'h8000_0200);
        check("int_code",   32'(bus.cp0_code_o), 32'd0);
        check("int_epc",    bus.cp0_epc_o, 32'h8000_4000);
        bus.status_ie_i = 1'b0;
        bus.hw_int_i    = '0;
        bus.cause_iv_i  = 1'b0;
        retire("int");
        step();
        step();
        check("int_drop", 32'(bus.int_pending_o), 32'h00);

        // SYS while memory busy: five busy cycles seen by the arbiter
        bus.exc_i[2]   = mk_exc(CODE_SYS, 32'h8000_5000, 32'h0, 1'b0);
        bus.mem_busy_i = 1'b1;
        stall_cnt = 0;
        step();
        clear_events();
        if (bus.stall_o) stall_cnt++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.stall_o) stall_cnt++;
            check("drain_no_rv", 32'(bus.redirect_valid_o), 32'd0);
        end
        bus.mem_busy_i = 1'b0;
        step();
        check("drain_stall_cnt", 32'(stall_cnt), 32'd5);
        check("drain_stall_off", 32'(bus.stall_o), 32'd0);
        check("drain_rv",        32'(bus.redirect_valid_o), 32'd1);
        check("drain_pc",        bus.redirect_pc_o, 32'h8000_0180);
        retire("drain");

        // ERET
        bus.epc_i  = 32'h8000_3000;
        bus.eret_i = 1'b1;
        step();
        check("eret_rv",     32'(bus.redirect_valid_o), 32'd1);
        check("eret_pc",     bus.redirect_pc_o, 32'h8000_3000);
        check("eret_clr",    32'(bus.exl_clr_o), 32'd1);
        check("eret_we",     32'(bus.cp0_we_o), 32'd0);
        check("eret_epcwe",  32'(bus.cp0_epc_we_o), 32'd0);
        check("eret_exlset", 32'(bus.exl_set_o), 32'd0);
        retire("eret");

        // ERET blocked by exception in the commit slot
        bus.eret_i   = 1'b1;
        bus.exc_i[2] = mk_exc(CODE_ADES, 32'h8000_6000, 32'h0000_6002, 1'b0);
        step();
        check("eretblk_code", 32'(bus.cp0_code_o), 32'd5);
        check("eretblk_clr",  32'(bus.exl_clr_o), 32'd0);
        check("eretblk_pc",   bus.redirect_pc_o, 32'h8000_0180);
        retire("eretblk");

        // Reset while draining
        bus.exc_i[2]   = mk_exc(CODE_SYS, 32'h8000_7000, 32'h0, 1'b0);
        bus.mem_busy_i = 1'b1;
        step();
        clear_events();
        check("rstdrain_stall_pre", 32'(bus.stall_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstdrain_stall", 32'(bus.stall_o), 32'd0);
        check("rstdrain_flush", 32'(bus.flush_o), 32'd0);
        check("rstdrain_rv",    32'(bus.redirect_valid_o), 32'd0);
        bus.mem_busy_i = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("rstdrain_no_rv", 32'(bus.redirect_valid_o), 32'd0);
        step();
        check("rstdrain_no_rv2", 32'(bus.redirect_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
